// File: rtl/full_adder_30_core_if.sv
// Operand/result bundle for the 30-bit word-address adder.
// The master side drives operands and the capture strobe; the slave side is the adder.
interface full_adder_30_core_if;
    logic [29:0] A;
    logic [29:0] B;
    logic        in_valid;
    logic [29:0] out30;
    logic [29:0] sum_q;
    logic        cout_q;
    logic        ovf_q;
    logic        out_valid;

    modport master (
        output A, B, in_valid,
        input  out30, sum_q, cout_q, ovf_q, out_valid
    );

    modport slave (
        input  A, B, in_valid,
        output out30, sum_q, cout_q, ovf_q, out_valid
    );
endinterface

// File: rtl/full_adder_30_core.sv
// 30-bit word-address adder: combinational sum for the PC mux plus a registered trace copy.
// Build option FA30_CLA_EN selects 4-bit carry-lookahead groups instead of a ripple chain.
module full_adder_30_core (
    input  logic                  clk,
    input  logic                  rst_n,
    full_adder_30_core_if.slave   bus
);

    logic [29:0] gen;
    logic [29:0] prop;
    logic [30:0] carry;
    logic [29:0] sum_c;
    logic        cout_c;
    logic        ovf_c;

    assign gen  = bus.A & bus.B;
    assign prop = bus.A ^ bus.B;

`ifdef FA30_CLA_EN
    // Each carry inside a group is expanded directly from the group carry-in;
    // only the group carries ripple. Groups start at 0,4,...,28 so the top group is bits 29:28.
    always_comb begin : cla_chain
        logic cj;
        logic prod;
        logic gcin;
        carry = '0;
        cj    = 1'b0;
        prod  = 1'b0;
        gcin  = 1'b0;
        for (int grp = 0; grp < 30; grp += 4) begin
            gcin = carry[grp];
            for (int j = grp; (j < grp + 4) && (j < 30); j++) begin
                cj   = gen[j];
                prod = prop[j];
                for (int m = j - 1; m >= grp; m--) begin
                    cj   = cj | (prod & gen[m]);
                    prod = prod & prop[m];
                end
                carry[j + 1] = cj | (prod & gcin);
            end
        end
    end
`else
    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (c & (a ^ b));
    endfunction

    always_comb begin : ripple_chain
        carry = '0;
        for (int i = 0; i < 30; i++) begin
            carry[i + 1] = fa_carry(bus.A[i], bus.B[i], carry[i]);
        end
    end
`endif

    assign sum_c  = prop ^ carry[29:0];
    assign cout_c = carry[30];
    assign ovf_c  = (bus.A[29] == bus.B[29]) && (sum_c[29] != bus.A[29]);

    assign bus.out30 = sum_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sum_q     <= '0;
            bus.cout_q    <= 1'b0;
            bus.ovf_q     <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum_q  <= sum_c;
                bus.cout_q <= cout_c;
                bus.ovf_q  <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_full_adder_30_core.sv
// Directed-vector bench for full_adder_30_core: combinational sum, registered flags,
// hold behaviour, asynchronous reset and back-to-back captures.
module tb_full_adder_30_core;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    full_adder_30_core_if bus_if ();

    full_adder_30_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector table: A, B, expected sum, carry, overflow (all hand-computed).
    localparam int NV = 9;
    logic [29:0] va   [NV] = '{30'h00400020, 30'h00400020, 30'h00400020, 30'h3FFFFFFF,
                               30'h1FFFFFFF, 30'h20000000, 30'h3FFFFFFF, 30'h0000000F,
                               30'h0FFFFFFF};
    logic [29:0] vb   [NV] = '{30'h00000001, 30'h00004000, 30'h3FFFFFE0, 30'h00000001,
                               30'h00000001, 30'h20000000, 30'h3FFFFFFF, 30'h00000001,
                               30'h00000001};
    logic [29:0] vsum [NV] = '{30'h00400021, 30'h00404020, 30'h00400000, 30'h00000000,
                               30'h20000000, 30'h00000000, 30'h3FFFFFFE, 30'h00000010,
                               30'h10000000};
    logic        vc   [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        vo   [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.A = 30'h00000005;
        bus_if.B = 30'h00000003;
        bus_if.in_valid = 1'b1;
        #12;
        n_checks++;
        if (bus_if.sum_q !== 30'h0 || bus_if.cout_q !== 1'b0 || bus_if.ovf_q !== 1'b0 ||
            bus_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: sum_q=%h cout_q=%b ovf_q=%b out_valid=%b expected 0/0/0/0",
                     bus_if.sum_q, bus_if.cout_q, bus_if.ovf_q, bus_if.out_valid);
        end
        n_checks++;
        if (bus_if.out30 !== 30'h00000008) begin
            n_fail++;
            $display("FAIL reset_out30: got %h expected 00000008", bus_if.out30);
        end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus_if.A = va[i];
            bus_if.B = vb[i];
            bus_if.in_valid = 1'b1;
            #1;
            n_checks++;
            if (bus_if.out30 !== vsum[i]) begin
                n_fail++;
                $display("FAIL vec%0d_out30: got %h expected %h", i, bus_if.out30, vsum[i]);
            end
            @(posedge clk);
            #1;
            bus_if.in_valid = 1'b0;
            n_checks++;
            if (bus_if.sum_q !== vsum[i] || bus_if.cout_q !== vc[i] || bus_if.ovf_q !== vo[i] ||
                bus_if.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL vec%0d_reg: sum_q=%h cout_q=%b ovf_q=%b out_valid=%b expected %h/%b/%b/1",
                         i, bus_if.sum_q, bus_if.cout_q, bus_if.ovf_q, bus_if.out_valid,
                         vsum[i], vc[i], vo[i]);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        bus_if.A = 30'h1FFFFFFF;
        bus_if.B = 30'h00000001;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.A = 30'h00000123;
        bus_if.B = 30'h00000456;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.sum_q !== 30'h20000000 ||
            bus_if.cout_q !== 1'b0 || bus_if.ovf_q !== 1'b1) begin
            n_fail++;
            $display("FAIL hold: sum_q=%h cout_q=%b ovf_q=%b out_valid=%b expected 20000000/0/1/0",
                     bus_if.sum_q, bus_if.cout_q, bus_if.ovf_q, bus_if.out_valid);
        end
        n_checks++;
        if (bus_if.out30 !== 30'h00000579) begin
            n_fail++;
            $display("FAIL hold_out30: got %h expected 00000579", bus_if.out30);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus_if.A = 30'h3FFFFFFF;
        bus_if.B = 30'h00000001;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.cout_q !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: out_valid=%b cout_q=%b expected 1/1",
                     bus_if.out_valid, bus_if.cout_q);
        end
        // Leave in_valid high: the pending capture must be discarded by the reset.
        bus_if.A = 30'h00001000;
        bus_if.B = 30'h00000234;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus_if.sum_q !== 30'h0 || bus_if.cout_q !== 1'b0 || bus_if.ovf_q !== 1'b0 ||
            bus_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_now: sum_q=%h cout_q=%b ovf_q=%b out_valid=%b expected 0/0/0/0",
                     bus_if.sum_q, bus_if.cout_q, bus_if.ovf_q, bus_if.out_valid);
        end
        n_checks++;
        if (bus_if.out30 !== 30'h00001234) begin
            n_fail++;
            $display("FAIL areset_out30: got %h expected 00001234", bus_if.out30);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.sum_q !== 30'h0) begin
            n_fail++;
            $display("FAIL areset_held: sum_q=%h out_valid=%b expected 0/0",
                     bus_if.sum_q, bus_if.out_valid);
        end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus_if.A = 30'h00000100;
        bus_if.B = 30'h00000200;
        bus_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.A = 30'h20000000;
        bus_if.B = 30'h3FFFFFFF;
        n_checks++;
        if (bus_if.sum_q !== 30'h00000300 || bus_if.out_valid !== 1'b1 ||
            bus_if.cout_q !== 1'b0 || bus_if.ovf_q !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: sum_q=%h cout_q=%b ovf_q=%b out_valid=%b expected 00000300/0/0/1",
                     bus_if.sum_q, bus_if.cout_q, bus_if.ovf_q, bus_if.out_valid);
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        // -2^29 + -1 overflows to the positive value 0x1FFFFFFF with a carry-out.
        n_checks++;
        if (bus_if.sum_q !== 30'h1FFFFFFF || bus_if.out_valid !== 1'b1 ||
            bus_if.cout_q !== 1'b1 || bus_if.ovf_q !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: sum_q=%h cout_q=%b ovf_q=%b out_valid=%b expected 1fffffff/1/1/1",
                     bus_if.sum_q, bus_if.cout_q, bus_if.ovf_q, bus_if.out_valid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.sum_q !== 30'h1FFFFFFF) begin
            n_fail++;
            $display("FAIL b2b_drop: sum_q=%h out_valid=%b expected 1fffffff/0",
                     bus_if.sum_q, bus_if.out_valid);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus_if.A = '0;
        bus_if.B = '0;
        bus_if.in_valid = 1'b0;
        test_reset();
        test_vectors();
        test_hold();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
